vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_controller.sv | 194 +++++++++++++++++++
 tb/tb_vend_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending machine controller: coin credit, item selection, dispense handshake
// with timeout/refund, and change pay-out. All outputs are registered.
module vend_controller #(
  parameter int PRICE_W       = 5,
  parameter int DEFAULT_PRICE = 3,
  parameter int DISP_TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coin_valid,
  input  logic [1:0]         in,
  input  logic               sel_valid,
  input  logic [1:0]         sel,
  input  logic               cancel,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_idx,
  input  logic [PRICE_W-1:0] cfg_price,
  output logic               disp_req,
  output logic [1:0]         disp_item,
  input  logic               disp_ack,
  output logic               change,
  output logic               reject,
  output logic               sel_nack,
  output logic               disp_fault,
  output logic [PRICE_W-1:0] credit,
  output logic               busy
);

  localparam int TW = (DISP_TIMEOUT > 1) ? $clog2(DISP_TIMEOUT + 1) : 1;
  localparam logic [PRICE_W-1:0] DEF_P    = PRICE_W'(DEFAULT_PRICE);
  localparam logic [TW-1:0]      TMO_LAST = TW'(DISP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [PRICE_W-1:0] credit_r, credit_s;
  logic [PRICE_W-1:0] price_r [4];
  logic [PRICE_W-1:0] paid_r, paid_s;
  logic [TW-1:0]      tmo_r, tmo_s;
  logic               disp_req_r, disp_req_s;
  logic [1:0]         disp_item_r, disp_item_s;
  logic               change_r, change_s;
  logic               reject_r, reject_s;
  logic               sel_nack_r, sel_nack_s;
  logic               disp_fault_r, disp_fault_s;
  logic               busy_r, busy_s;

  logic [1:0]         coin_amt_s;
  logic [PRICE_W:0]   sum_s;
  logic               coin_ok_s;
  logic [PRICE_W-1:0] sel_price_s;
  logic               sel_ok_s;

  // Coin arithmetic and selection affordability
  always_comb begin
    coin_amt_s  = (in == 2'd2) ? 2'd2 : 2'd1;
    sum_s       = {1'b0, credit_r} + {{(PRICE_W - 1){1'b0}}, coin_amt_s};
    coin_ok_s   = ((in == 2'd1) || (in == 2'd2)) && !sum_s[PRICE_W];
    sel_price_s = price_r[sel];
    sel_ok_s    = (sel_price_s != {PRICE_W{1'b0}}) && (credit_r >= sel_price_s);
  end

  // Next-state and next-output logic
  always_comb begin
    state_s      = state_r;
    credit_s     = credit_r;
    paid_s       = paid_r;
    tmo_s        = tmo_r;
    disp_req_s   = disp_req_r;
    disp_item_s  = disp_item_r;
    change_s     = 1'b0;
    reject_s     = 1'b0;
    sel_nack_s   = 1'b0;
    disp_fault_s = 1'b0;
    case (state_r)
      IDLE, COLLECT: begin
        if (cancel && (state_r == COLLECT)) begin
          state_s  = CHANGE;
          reject_s = coin_valid;
        end else if (sel_valid && sel_ok_s) begin
          credit_s    = credit_r - sel_price_s;
          paid_s      = sel_price_s;
          tmo_s       = {TW{1'b0}};
          disp_req_s  = 1'b1;
          disp_item_s = sel;
          state_s     = DISPENSE;
          reject_s    = coin_valid;
        end else begin
          sel_nack_s = sel_valid;
          if (coin_valid && coin_ok_s) begin
            credit_s = sum_s[PRICE_W-1:0];
            state_s  = COLLECT;
          end else begin
            reject_s = coin_valid;
          end
        end
      end
      DISPENSE: begin
        reject_s = coin_valid;
        if (disp_ack) begin
          disp_req_s  = 1'b0;
          disp_item_s = 2'd0;
          tmo_s       = {TW{1'b0}};
          state_s     = (credit_r != {PRICE_W{1'b0}}) ? CHANGE : IDLE;
        end else if (tmo_r == TMO_LAST) begin
          // Mechanism never answered: refund what this dispense cost
          disp_fault_s = 1'b1;
          credit_s     = credit_r + paid_r;
          disp_req_s   = 1'b0;
          disp_item_s  = 2'd0;
          tmo_s        = {TW{1'b0}};
          state_s      = CHANGE;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      CHANGE: begin
        reject_s = coin_valid;
        if (credit_r != {PRICE_W{1'b0}}) begin
          change_s = 1'b1;
          credit_s = credit_r - PRICE_W'(1);
          state_s  = (credit_r == PRICE_W'(1)) ? IDLE : CHANGE;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s     = IDLE;
        credit_s    = {PRICE_W{1'b0}};
        disp_req_s  = 1'b0;
        disp_item_s = 2'd0;
        tmo_s       = {TW{1'b0}};
      end
    endcase
    busy_s = (state_s == DISPENSE) || (state_s == CHANGE);
  end

  // State, credit and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      credit_r     <= {PRICE_W{1'b0}};
      paid_r       <= {PRICE_W{1'b0}};
      tmo_r        <= {TW{1'b0}};
      disp_req_r   <= 1'b0;
      disp_item_r  <= 2'd0;
      change_r     <= 1'b0;
      reject_r     <= 1'b0;
      sel_nack_r   <= 1'b0;
      disp_fault_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      credit_r     <= credit_s;
      paid_r       <= paid_s;
      tmo_r        <= tmo_s;
      disp_req_r   <= disp_req_s;
      disp_item_r  <= disp_item_s;
      change_r     <= change_s;
      reject_r     <= reject_s;
      sel_nack_r   <= sel_nack_s;
      disp_fault_r <= disp_fault_s;
      busy_r       <= busy_s;
    end
  end

  // Price table; a running dispense uses its captured paid_r, not this table
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        price_r[i] <= DEF_P;
      end
    end else if (cfg_we) begin
      price_r[cfg_idx] <= cfg_price;
    end else begin
      price_r <= price_r;
    end
  end

  assign disp_req   = disp_req_r;
  assign disp_item  = disp_item_r;
  assign change     = change_r;
  assign reject     = reject_r;
  assign sel_nack   = sel_nack_r;
  assign disp_fault = disp_fault_r;
  assign credit     = credit_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: directed stimulus pushes expected
// output events; a negedge monitor pops and compares whenever outputs change.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [1:0] in;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [4:0] cfg_price;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       disp_ack;
  logic       change;
  logic       reject;
  logic       sel_nack;
  logic       disp_fault;
  logic [4:0] credit;
  logic       busy;

  vend_controller #(.PRICE_W(5), .DEFAULT_PRICE(3), .DISP_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .in(in),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_price(cfg_price),
    .disp_req(disp_req), .disp_item(disp_item), .disp_ack(disp_ack),
    .change(change), .reject(reject), .sel_nack(sel_nack),
    .disp_fault(disp_fault), .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct packed {
    logic       reject;
    logic       sel_nack;
    logic       change;
    logic       disp_fault;
    logic       disp_req;
    logic [1:0] item;
    logic       busy;
    logic [4:0] credit;
  } snap_t;

  snap_t expq[$];
  string tagq[$];
  int    tests = 0;
  int    fails = 0;
  snap_t cur, prev, e;
  string t;

  function automatic snap_t mk(input logic rj, input logic nk, input logic ch,
                               input logic fl, input logic rq, input logic [1:0] it,
                               input logic bz, input logic [4:0] cr);
    snap_t s;
    s.reject = rj; s.sel_nack = nk; s.change = ch; s.disp_fault = fl;
    s.disp_req = rq; s.item = it; s.busy = bz; s.credit = cr;
    return s;
  endfunction

  function automatic snap_t get_snap();
    return mk(reject, sel_nack, change, disp_fault, disp_req, disp_item, busy, credit);
  endfunction

  task automatic expect_ev(input string tag, input snap_t s);
    expq.push_back(s);
    tagq.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] c);
    coin_valid = 1'b1; in = c; tick(); coin_valid = 1'b0;
  endtask

  task automatic do_sel(input logic [1:0] s);
    sel_valid = 1'b1; sel = s; tick(); sel_valid = 1'b0;
  endtask

  task automatic ack();
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1; tick(); cancel = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [4:0] p);
    cfg_we = 1'b1; cfg_idx = idx; cfg_price = p; tick(); cfg_we = 1'b0;
  endtask

  // Monitor: an event is any pulse, a disp_req/busy edge, or a credit change
  always @(negedge clk) begin
    cur = get_snap();
    if (!reset && (cur.reject || cur.sel_nack || cur.change || cur.disp_fault ||
                   cur.disp_req != prev.disp_req || cur.busy != prev.busy ||
                   cur.credit != prev.credit)) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got=%h required=none", cur);
      end else begin
        e = expq.pop_front();
        t = tagq.pop_front();
        if (cur !== e) begin
          fails++;
          $display("FAIL %s: got=%h required=%h", t, cur, e);
        end
      end
    end
    prev = cur;
  end

  initial begin
    int t0;
    int t1;
    prev = '0;
    reset = 1'b1;
    coin_valid = 1'b0; in = 2'd0; sel_valid = 1'b0; sel = 2'd0;
    cancel = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0; cfg_price = 5'd0; disp_ack = 1'b0;
    #2;
    tests++;
    if (get_snap() !== '0) begin
      fails++;
      $display("FAIL reset_state: got=%h required=0", get_snap());
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Exact payment after a refused selection, no change
    expect_ev("a_coin1", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd1));     coin(2'd1);
    expect_ev("a_coin2", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd2));     coin(2'd1);
    expect_ev("a_nack", mk(0, 1, 0, 0, 0, 2'd0, 0, 5'd2));      do_sel(2'd0);
    expect_ev("a_coin3", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd3));     coin(2'd1);
    expect_ev("a_disp", mk(0, 0, 0, 0, 1, 2'd0, 1, 5'd0));      do_sel(2'd0);
    repeat (2) tick();
    expect_ev("a_ack", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd0));       ack();
    repeat (3) tick();

    // Overpay by one step, one change coin after ack
    expect_ev("b_coin1", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd2));     coin(2'd2);
    expect_ev("b_coin2", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd4));     coin(2'd2);
    expect_ev("b_disp", mk(0, 0, 0, 0, 1, 2'd1, 1, 5'd1));      do_sel(2'd1);
    expect_ev("b_ack", mk(0, 0, 0, 0, 0, 2'd0, 1, 5'd1));
    expect_ev("b_chg", mk(0, 0, 1, 0, 0, 2'd0, 0, 5'd0));       ack();
    repeat (3) tick();

    // Cancel beats a same-cycle coin (rejected) and sel (dropped)
    expect_ev("c_coin1", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd1));     coin(2'd1);
    expect_ev("c_coin2", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd2));     coin(2'd1);
    expect_ev("c_cancel", mk(1, 0, 0, 0, 0, 2'd0, 1, 5'd2));
    expect_ev("c_chg1", mk(0, 0, 1, 0, 0, 2'd0, 1, 5'd1));
    expect_ev("c_chg0", mk(0, 0, 1, 0, 0, 2'd0, 0, 5'd0));
    coin_valid = 1'b1; in = 2'd1; sel_valid = 1'b1; sel = 2'd0;
    do_cancel();
    coin_valid = 1'b0; sel_valid = 1'b0;
    repeat (4) tick();

    // Dispense timeout refunds the captured price despite a mid-dispense price write
    expect_ev("d_coin1", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd2));     coin(2'd2);
    expect_ev("d_coin2", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd4));     coin(2'd2);
    expect_ev("d_disp", mk(0, 0, 0, 0, 1, 2'd0, 1, 5'd1));      do_sel(2'd0);
    t0 = cycle;
    expect_ev("d_rej_busy", mk(1, 0, 0, 0, 1, 2'd0, 1, 5'd1));  coin(2'd3);
    cfg(2'd0, 5'd7);
    expect_ev("d_fault", mk(0, 0, 0, 1, 0, 2'd0, 1, 5'd4));
    expect_ev("d_chg3", mk(0, 0, 1, 0, 0, 2'd0, 1, 5'd3));
    expect_ev("d_chg2", mk(0, 0, 1, 0, 0, 2'd0, 1, 5'd2));
    expect_ev("d_chg1", mk(0, 0, 1, 0, 0, 2'd0, 1, 5'd1));
    expect_ev("d_chg0", mk(0, 0, 1, 0, 0, 2'd0, 0, 5'd0));
    for (int n = 0; n < 40 && !disp_fault; n++) tick();
    t1 = cycle;
    tests++;
    if (!disp_fault || (t1 - t0) != 15) begin
      fails++;
      $display("FAIL fault_latency: got=%0d cycles (fault=%0b) required=15", t1 - t0, disp_fault);
    end
    repeat (6) tick();

    // Credit ceiling and invalid coin codes
    for (int k = 1; k <= 15; k++) begin
      expect_ev("e_fill", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'(2 * k)));
      coin(2'd2);
    end
    expect_ev("e_rej_ovf2", mk(1, 0, 0, 0, 0, 2'd0, 0, 5'd30)); coin(2'd2);
    expect_ev("e_rej_in3", mk(1, 0, 0, 0, 0, 2'd0, 0, 5'd30));  coin(2'd3);
    expect_ev("e_rej_in0", mk(1, 0, 0, 0, 0, 2'd0, 0, 5'd30));  coin(2'd0);
    expect_ev("e_max", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd31));      coin(2'd1);
    expect_ev("e_rej_ovf1", mk(1, 0, 0, 0, 0, 2'd0, 0, 5'd31)); coin(2'd1);
    expect_ev("e_cancel", mk(0, 0, 0, 0, 0, 2'd0, 1, 5'd31));
    for (int k = 30; k >= 0; k--) begin
      expect_ev("e_chg", mk(0, 0, 1, 0, 0, 2'd0, (k != 0), 5'(k)));
    end
    do_cancel();
    repeat (33) tick();

    // Reset during CHANGE; prices return to default
    cfg(2'd2, 5'd1);
    expect_ev("f_coin1", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd2));     coin(2'd2);
    expect_ev("f_coin2", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd3));     coin(2'd1);
    expect_ev("f_cancel", mk(0, 0, 0, 0, 0, 2'd0, 1, 5'd3));    do_cancel();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    tests++;
    if (get_snap() !== '0) begin
      fails++;
      $display("FAIL reset_async: got=%h required=0", get_snap());
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) tick();
    expect_ev("f_coin3", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd1));     coin(2'd1);
    expect_ev("f_coin4", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd2));     coin(2'd1);
    expect_ev("f_nack_defprice", mk(0, 1, 0, 0, 0, 2'd0, 0, 5'd2)); do_sel(2'd2);
    expect_ev("f_coin5", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd3));     coin(2'd1);
    expect_ev("f_disp2", mk(0, 0, 0, 0, 1, 2'd2, 1, 5'd0));     do_sel(2'd2);
    expect_ev("f_ack", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd0));       ack();
    tick();

    // Price 0 disables an item even with credit available
    cfg(2'd3, 5'd0);
    expect_ev("g_coin", mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd1));      coin(2'd1);
    expect_ev("g_nack_disabled", mk(0, 1, 0, 0, 0, 2'd0, 0, 5'd1)); do_sel(2'd3);
    expect_ev("g_cancel", mk(0, 0, 0, 0, 0, 2'd0, 1, 5'd1));
    expect_ev("g_chg0", mk(0, 0, 1, 0, 0, 2'd0, 0, 5'd0));
    do_cancel();
    repeat (5) tick();

    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL leftover_events: got=%0d pending required=0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
